multicycle_main_controller: RTL

- Main control FSM of the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives all datapath mux selects and write enables, and produces the 2-bit ALUOp that the ALU controller decodes together with func3/func7.
- Sits upstream of the ALU controller, between the instruction register and the datapath.

---
 rtl/riscv_ctrl_pkg.sv | 55 +++++
 rtl/imm_src_decoder.sv | 20 ++
 rtl/multicycle_main_controller.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core: FSM states, opcodes
// and the mux/ALUOp select codes used by the main and ALU controllers.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I,
        ALU_WB, BRANCH, JAL, JALR, LINK, LUI
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Unsupported func3 codes fall through as not-taken rather than illegal.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                          input logic n);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return n;
            3'b101:  return ~n;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode -> immediate-format select for the immediate generator.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_src = IMM_I;
            OP_STORE:                   imm_src = IMM_S;
            OP_BRANCH:                  imm_src = IMM_B;
            OP_JAL:                     imm_src = IMM_J;
            OP_LUI:                     imm_src = IMM_U;
            default:                    imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main control FSM of the multicycle RV32I core: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives datapath controls.
module multicycle_main_controller
    import riscv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_illegal;
    logic [2:0] w_imm_src;

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (w_imm_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RESET_STATE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = MEM_ADR;
                    OP_RTYPE:          w_next = EXEC_R;
                    OP_ITYPE:          w_next = EXEC_I;
                    OP_BRANCH:         w_next = BRANCH;
                    OP_JAL:            w_next = JAL;
                    OP_JALR:           w_next = JALR;
                    OP_LUI:            w_next = LUI;
                    default:           w_next = FETCH;
                endcase
            end
            MEM_ADR: w_next = (op == OP_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:  w_next = MEM_WB;
            EXEC_R:  w_next = ALU_WB;
            EXEC_I:  w_next = ALU_WB;
            JAL:     w_next = LINK;
            JALR:    w_next = LINK;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RD2;
        w_alu_op     = ALUOP_ADD;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            FETCH: begin
                w_ir_write   = 1'b1;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURES;
                w_pc_update  = 1'b1;
            end
            DECODE: begin
                w_src_a = SRCA_OLDPC;
                w_src_b = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
                    OP_BRANCH, OP_JAL, OP_JALR, OP_LUI: w_illegal = 1'b0;
                    default:                            w_illegal = 1'b1;
                endcase
            end
            MEM_ADR: begin
                w_src_a = SRCA_RD1;
                w_src_b = SRCB_IMM;
            end
            MEM_RD: w_adr_src = 1'b1;
            MEM_WB: begin
                w_result_src = RES_MEM;
                w_reg_write  = 1'b1;
            end
            MEM_WR: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            EXEC_R: begin
                w_src_a  = SRCA_RD1;
                w_alu_op = ALUOP_RTYPE;
            end
            EXEC_I: begin
                w_src_a  = SRCA_RD1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_ITYPE;
            end
            ALU_WB: w_reg_write = 1'b1;
            BRANCH: begin
                w_src_a  = SRCA_RD1;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
            end
            JAL: w_pc_update = 1'b1;
            JALR: begin
                w_src_a      = SRCA_RD1;
                w_src_b      = SRCB_IMM;
                w_result_src = RES_ALURES;
                w_pc_update  = 1'b1;
            end
            LINK: begin
                w_src_a      = SRCA_OLDPC;
                w_src_b      = SRCB_FOUR;
                w_result_src = RES_ALURES;
                w_reg_write  = 1'b1;
            end
            LUI: begin
                w_result_src = RES_IMM;
                w_reg_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs are forced idle while reset is held so an in-flight write aborts at once.
    assign PCWrite   = rst_n & (w_pc_update | (w_branch & branch_taken(func3, zero, neg)));
    assign AdrSrc    = rst_n & w_adr_src;
    assign MemWrite  = rst_n & w_mem_write;
    assign IRWrite   = rst_n & w_ir_write;
    assign ResultSrc = rst_n ? w_result_src : 2'b00;
    assign ALUSrcA   = rst_n ? w_src_a : 2'b00;
    assign ALUSrcB   = rst_n ? w_src_b : 2'b00;
    assign ALUOp     = rst_n ? w_alu_op : 2'b00;
    assign ImmSrc    = rst_n ? w_imm_src : 3'b000;
    assign RegWrite  = rst_n & w_reg_write;
    assign illegal   = rst_n & w_illegal;

endmodule
